// File: rtl/memory_responder.sv
// memory_responder: memory-side end of the per-channel valid/ready memory protocol.
//
// Every channel runs its own FSM. The FSM accepts one read or one write, waits
// LATENCY cycles, completes the request against a shared 2^ADDR_BITS x DATA_BITS
// array, and then holds *_ready high until the initiator drops *_valid.
// Preload port (load_*) writes the array directly and ignores WRITE_ENABLE, so the
// block can also serve as a program memory.
//
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   read_valid       per-channel read request
//   read_address     per-channel read address
//   read_ready       per-channel read complete; read_data is valid while high
//   read_data        per-channel returned word (holds its last value)
//   write_valid      per-channel write request
//   write_address    per-channel write address
//   write_data       per-channel write word
//   write_ready      per-channel write committed
//   load_en          preload write strobe
//   load_address     preload address
//   load_data        preload word
module memory_responder #(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 16,
    parameter int unsigned NUM_CHANNELS = 1,
    parameter int unsigned WRITE_ENABLE = 1,
    parameter int unsigned LATENCY      = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CHANNELS-1:0]                 read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  read_address,
    output logic [NUM_CHANNELS-1:0]                 read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  read_data,
    input  logic [NUM_CHANNELS-1:0]                 write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  write_data,
    output logic [NUM_CHANNELS-1:0]                 write_ready,
    input  logic                                    load_en,
    input  logic [ADDR_BITS-1:0]                    load_address,
    input  logic [DATA_BITS-1:0]                    load_data
);

    localparam int unsigned Depth   = 1 << ADDR_BITS;
    localparam int unsigned CntBits = $clog2(LATENCY + 1);
    localparam logic [CntBits-1:0] CntInit = CntBits'(LATENCY - 1);
    localparam bit WrEn = (WRITE_ENABLE != 0);

    typedef enum logic [1:0] {
        RespIdle,
        RespRead,
        RespWrite,
        RespDone
    } resp_state_e;

    resp_state_e                               state_q [NUM_CHANNELS];
    resp_state_e                               state_d [NUM_CHANNELS];
    logic [CntBits-1:0]                        count_q [NUM_CHANNELS];
    logic [CntBits-1:0]                        count_d [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]                      addr_q  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]                      addr_d  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]                      data_q  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]                      data_d  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]                   read_ready_q, read_ready_d;
    logic [NUM_CHANNELS-1:0]                   write_ready_q, write_ready_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    read_data_q, read_data_d;
    logic [NUM_CHANNELS-1:0]                   commit;
    logic [DATA_BITS-1:0]                      mem_q [Depth];

    // Per-channel next-state and output logic.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            state_d[i]       = state_q[i];
            count_d[i]       = count_q[i];
            addr_d[i]        = addr_q[i];
            data_d[i]        = data_q[i];
            read_ready_d[i]  = read_ready_q[i];
            write_ready_d[i] = write_ready_q[i];
            read_data_d[i]   = read_data_q[i];
            commit[i]        = 1'b0;

            case (state_q[i])
                RespIdle: begin
                    // Read wins; a concurrent write stays pending until the read finishes.
                    if (read_valid[i]) begin
                        addr_d[i]  = read_address[i];
                        count_d[i] = CntInit;
                        state_d[i] = RespRead;
                    end else if (WrEn && write_valid[i]) begin
                        addr_d[i]  = write_address[i];
                        data_d[i]  = write_data[i];
                        count_d[i] = CntInit;
                        state_d[i] = RespWrite;
                    end
                end
                RespRead: begin
                    if (count_q[i] == '0) begin
                        // mem_q is the pre-edge array, so a same-edge write returns old data.
                        read_data_d[i]  = mem_q[addr_q[i]];
                        read_ready_d[i] = 1'b1;
                        state_d[i]      = RespDone;
                    end else begin
                        count_d[i] = count_q[i] - CntBits'(1);
                    end
                end
                RespWrite: begin
                    if (count_q[i] == '0) begin
                        commit[i]        = 1'b1;
                        write_ready_d[i] = 1'b1;
                        state_d[i]       = RespDone;
                    end else begin
                        count_d[i] = count_q[i] - CntBits'(1);
                    end
                end
                RespDone: begin
                    // The ready bit that is set tells which valid this handshake belongs to.
                    if (read_ready_q[i] ? !read_valid[i] : !write_valid[i]) begin
                        read_ready_d[i]  = 1'b0;
                        write_ready_d[i] = 1'b0;
                        state_d[i]       = RespIdle;
                    end
                end
                default: state_d[i] = RespIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i] <= RespIdle;
                count_q[i] <= '0;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
            end
            read_ready_q  <= '0;
            write_ready_q <= '0;
            read_data_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
                addr_q[i]  <= addr_d[i];
                data_q[i]  <= data_d[i];
            end
            read_ready_q  <= read_ready_d;
            write_ready_q <= write_ready_d;
            read_data_q   <= read_data_d;
        end
    end

    // Array. Later non-blocking assignments win, so the ascending channel loop
    // lets the highest channel win, and the preload placed last beats them all.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < Depth; a++) begin
                mem_q[a] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (commit[i]) begin
                    mem_q[addr_q[i]] <= data_q[i];
                end
            end
            if (load_en) begin
                mem_q[load_address] <= load_data;
            end
        end
    end

    assign read_ready  = read_ready_q;
    assign write_ready = write_ready_q;
    assign read_data   = read_data_q;

endmodule

// File: doc/memory_responder.md
# memory_responder

Synthesizable global-memory responder: the memory-side end of the per-channel valid/ready memory protocol that the memory controller issues on.
- Each channel has an independent FSM. It accepts one read or write request, waits a fixed `LATENCY`, then completes it against an internal `2^ADDR_BITS` x `DATA_BITS` array.
- It holds `*_ready` until the initiator drops `*_valid`.
- Used as data memory (`WRITE_ENABLE=1`) or as program memory (`WRITE_ENABLE=0`, contents loaded through the preload port).

## Interface
Parameters:
- `ADDR_BITS`, 8: address width; array depth is `2^ADDR_BITS`.
- `DATA_BITS`, 16: word width.
- `NUM_CHANNELS`, 1: number of independent request channels.
- `WRITE_ENABLE`, 1: 0 makes the block read-only on the channels.
- `LATENCY`, 2: cycles from request acceptance to `*_ready` rising; legal range is 1 or more.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `read_valid`  in  [NUM_CHANNELS]  read request per channel.
- `read_address`  in  [NUM_CHANNELS][ADDR_BITS]  read address.
- `read_ready`  out  [NUM_CHANNELS]  read complete; `read_data` is valid while this is high.
- `read_data`  out  [NUM_CHANNELS][DATA_BITS]  returned word.
- `write_valid`  in  [NUM_CHANNELS]  write request per channel.
- `write_address`  in  [NUM_CHANNELS][ADDR_BITS]  write address.
- `write_data`  in  [NUM_CHANNELS][DATA_BITS]  write word.
- `write_ready`  out  [NUM_CHANNELS]  write committed.
- `load_en`  in  1  preload write strobe; works regardless of `WRITE_ENABLE`.
- `load_address`  in  ADDR_BITS  preload address.
- `load_data`  in  DATA_BITS  preload word.

## Operation
Per-channel states are RESP_IDLE, RESP_READ, RESP_WRITE and RESP_DONE. Each channel also has a latched address, a latched data word and a `$clog2(LATENCY+1)`-bit down-counter.

- **RESP_IDLE**
  - If `read_valid[i]`: latch `read_address[i]`, set count to `LATENCY-1`, go to RESP_READ.
  - Else if `write_valid[i]` and `WRITE_ENABLE`: latch address and data, set count to `LATENCY-1`, go to RESP_WRITE.
  - Read has priority when both are high. The write stays pending and is taken after the read returns to idle.
  - With `WRITE_ENABLE=0`, `write_valid` is ignored forever and `write_ready` stays 0.
- **RESP_READ**
  - If count is 0: `read_data[i] <= mem[latched addr]`, `read_ready[i] <= 1`, go to RESP_DONE.
  - Otherwise decrement count.
- **RESP_WRITE**
  - If count is 0: `mem[latched addr] <= latched data`, `write_ready[i] <= 1`, go to RESP_DONE.
  - Otherwise decrement count.
- **RESP_DONE**
  - Stay while the matching `*_valid[i]` is 1.
  - When it is sampled 0: clear that `*_ready[i]` and go to RESP_IDLE.
  - `read_data[i]` holds its last value and is not cleared.
- **Requests are not abortable.** If `*_valid` drops during RESP_READ or RESP_WRITE, the operation still completes (the write still commits). The channel then enters RESP_DONE, sees valid low on the next edge and returns to idle, producing a 1-cycle `*_ready` pulse.
- **Simultaneous array writes to the same address on one edge:**
  - `load_en` beats all channel writes.
  - Among channels, the highest channel index wins.
- **Read/write ordering:** a read completing on the same edge as a write to the same address returns the old value; the array update is non-blocking.
- **Reset** (asynchronous, any time, including mid-operation):
  - all channels go to RESP_IDLE;
  - `read_ready`, `write_ready` and `read_data` clear to 0;
  - the counters clear;
  - the array clears to 0;
  - in-flight requests are dropped with no commit.

## Timing
- The acceptance edge is edge k, the first rising edge with `*_valid` high in RESP_IDLE. `*_ready` is registered high after edge k+`LATENCY`. With `LATENCY=1` it rises after edge k+1.
- `*_ready` falls after the first edge at which `*_valid` is sampled low in RESP_DONE.
- The earliest next acceptance on the same channel is the edge after that.
- A channel therefore cannot see a stale `*_ready` from a previous request.
- `load_en` writes take effect at the edge where they are sampled.
- Channels are fully concurrent; there are no cross-channel stalls.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- **Preload and read.** Preload `mem[0x10]=0xBEEF`. `LATENCY=2`, ch0 `read_valid` at edge 5 with address 0x10 → `read_ready` high after edge 7 with `read_data=0xBEEF`. Drop valid at edge 9 → ready low after edge 9.
- **Write then read.** Ch0 writes 0x1234 to 0x20 → `write_ready` after acceptance+2. Drop valid, then read 0x20 → 0x1234.
- **Dual-channel collision.** `NUM_CHANNELS=2`. Both channels write to 0x30 in the same cycle (ch0 0x1111, ch1 0x2222) → both get `write_ready`; a later read returns 0x2222. A `load_en` to 0x30 on the same edge instead yields the load value.
- **Read-only and priority.** With `WRITE_ENABLE=0`, `write_valid` held 10 cycles → `write_ready` stays 0 and the array is unchanged. With both read and write valid → the read is served first and the write follows after the read handshake.
- **Early drop.** `read_valid` dropped at acceptance+1 → a 1-cycle `read_ready` pulse at acceptance+2, then idle.
- **Reset mid-operation.** Assert `reset` asynchronously during RESP_WRITE → outputs 0 immediately, the write is not committed (readback 0), and the next request is accepted normally.
